// File: rtl/darkspi_slave_if.sv
// Signal bundle for darkspi_slave: SPI pins plus the byte-wide local RX/TX handshakes.
interface darkspi_slave_if #(
   parameter int unsigned WIDTH = 8
);
   logic             SPI_SCK;
   logic             SPI_MOSI;
   logic             SPI_CSN;
   logic             SPI_MISO;
   logic             SPI_MISO_OE;
   logic [WIDTH-1:0] TX_DATA;
   logic             TX_VALID;
   logic             TX_READY;
   logic [WIDTH-1:0] RX_DATA;
   logic             RX_VALID;
   logic             RX_READY;
   logic             BUSY;
   logic             OVERRUN;
   logic             UNDERRUN;
   logic             ERR_CLR;

   modport slave (
      input  SPI_SCK, SPI_MOSI, SPI_CSN, TX_DATA, TX_VALID, RX_READY, ERR_CLR,
      output SPI_MISO, SPI_MISO_OE, TX_READY, RX_DATA, RX_VALID, BUSY, OVERRUN, UNDERRUN
   );

   modport master (
      output SPI_SCK, SPI_MOSI, SPI_CSN, TX_DATA, TX_VALID, RX_READY, ERR_CLR,
      input  SPI_MISO, SPI_MISO_OE, TX_READY, RX_DATA, RX_VALID, BUSY, OVERRUN, UNDERRUN
   );
endinterface

// File: rtl/darkspi_slave.sv
// SPI mode-0 responder, MSB first. SPI pins are oversampled in the CLK domain; words are
// exchanged with local logic through valid/ready handshakes with sticky error flags.
module darkspi_slave #(
   parameter int unsigned      WIDTH       = 8,
   parameter int unsigned      SYNC_STAGES = 2,
   parameter logic [WIDTH-1:0] IDLE_WORD   = 8'hFF
) (
   input logic            CLK,
   input logic            RES,
   darkspi_slave_if.slave bus
);

   localparam int unsigned    CW       = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, csn_sync;
   logic                   sck_dly, csn_dly;
   logic                   sck_s, mosi_s, csn_s;
   logic                   selected, sck_rise, sck_fall, csn_fall, csn_rise, tx_load;

   logic [CW-1:0]    cnt_q, cnt_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] rx_shift_q, rx_shift_d, rx_word;
   logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic             hold_full_q, hold_full_d;
   logic [WIDTH-1:0] rx_data_q, rx_data_d;
   logic             rx_valid_q, rx_valid_d;
   logic             overrun_q, overrun_d;
   logic             underrun_q, underrun_d;

   always_ff @(posedge CLK or negedge RES) begin
      if (!RES) begin
         sck_sync  <= '0;
         mosi_sync <= '0;
         csn_sync  <= '1;
         sck_dly   <= 1'b0;
         csn_dly   <= 1'b1;
      end else begin
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.SPI_SCK};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.SPI_MOSI};
         csn_sync  <= {csn_sync[SYNC_STAGES-2:0], bus.SPI_CSN};
         sck_dly   <= sck_sync[SYNC_STAGES-1];
         csn_dly   <= csn_sync[SYNC_STAGES-1];
      end
   end

   assign sck_s  = sck_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];
   assign csn_s  = csn_sync[SYNC_STAGES-1];

   // SCK edges count only once the select has fully settled low.
   assign selected = ~csn_s & ~csn_dly;
   assign sck_rise = selected & sck_s & ~sck_dly;
   assign sck_fall = selected & ~sck_s & sck_dly;
   assign csn_fall = ~csn_s & csn_dly;
   assign csn_rise = csn_s & ~csn_dly;

   // The falling edge that ends a word fetches the next one; the very first falling edge
   // of a selection never sees cnt_q == 0 together with done_q.
   assign tx_load = csn_fall | (sck_fall & (cnt_q == '0) & done_q);
   assign rx_word = {rx_shift_q[WIDTH-2:0], mosi_s};

   always_comb begin
      cnt_d       = cnt_q;
      done_d      = done_q;
      rx_shift_d  = rx_shift_q;
      tx_shift_d  = tx_shift_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = rx_valid_q;
      overrun_d   = overrun_q;
      underrun_d  = underrun_q;

      // Clear first so a same-cycle error event below overrides it.
      if (bus.ERR_CLR) begin
         overrun_d  = 1'b0;
         underrun_d = 1'b0;
      end
      if (rx_valid_q && bus.RX_READY) rx_valid_d = 1'b0;

      if (csn_fall || csn_rise) begin
         cnt_d      = '0;
         done_d     = 1'b0;
         rx_shift_d = '0;
      end

      if (sck_rise) begin
         rx_shift_d = rx_word;
         if (cnt_q == LAST_BIT) begin
            cnt_d  = '0;
            done_d = 1'b1;
            if (!rx_valid_q || bus.RX_READY) begin
               rx_data_d  = rx_word;
               rx_valid_d = 1'b1;
            end else begin
               overrun_d = 1'b1;
            end
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end

      if (tx_load) begin
         if (hold_full_q) begin
            tx_shift_d  = hold_q;
            hold_full_d = 1'b0;
         end else begin
            tx_shift_d = IDLE_WORD;
            underrun_d = 1'b1;
         end
      end else if (sck_fall && (cnt_q != '0)) begin
         tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
      end

      // Writes land only in an empty holding register, so they never race a load's clear.
      if (bus.TX_VALID && !hold_full_q) begin
         hold_d      = bus.TX_DATA;
         hold_full_d = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RES) begin
      if (!RES) begin
         cnt_q       <= '0;
         done_q      <= 1'b0;
         rx_shift_q  <= '0;
         tx_shift_q  <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         overrun_q   <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         done_q      <= done_d;
         rx_shift_q  <= rx_shift_d;
         tx_shift_q  <= tx_shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         overrun_q   <= overrun_d;
         underrun_q  <= underrun_d;
      end
   end

   assign bus.SPI_MISO_OE = ~csn_dly;
   assign bus.BUSY        = ~csn_dly;
   assign bus.SPI_MISO    = ~csn_dly & tx_shift_q[WIDTH-1];
   assign bus.TX_READY    = ~hold_full_q;
   assign bus.RX_DATA     = rx_data_q;
   assign bus.RX_VALID    = rx_valid_q;
   assign bus.OVERRUN     = overrun_q;
   assign bus.UNDERRUN    = underrun_q;

endmodule

// File: tb/tb_darkspi_slave.sv
// Bench for darkspi_slave: a bit-banged SPI master driving directed and random sessions,
// checked against a word-level model of the holding register, RX word and error flags.
module tb_darkspi_slave;
   localparam int unsigned WIDTH       = 8;
   localparam int unsigned SYNC_STAGES = 2;
   localparam int unsigned PH          = 6;
   localparam logic [7:0]  IDLE        = 8'hFF;

   logic clk   = 1'b0;
   logic res_n = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   darkspi_slave_if #(.WIDTH(WIDTH)) bus ();

   darkspi_slave #(
      .WIDTH      (WIDTH),
      .SYNC_STAGES(SYNC_STAGES),
      .IDLE_WORD  (IDLE)
   ) dut (
      .CLK(clk),
      .RES(res_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Word-level model state.
   logic       m_hold_full = 1'b0;
   logic [7:0] m_hold      = '0;
   logic       m_rx_valid  = 1'b0;
   logic [7:0] m_rx_data   = '0;
   logic       m_ov        = 1'b0;
   logic       m_un        = 1'b0;
   logic [7:0] m_cur       = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic m_load(output logic [7:0] w);
      if (m_hold_full) begin
         w           = m_hold;
         m_hold_full = 1'b0;
      end else begin
         w    = IDLE;
         m_un = 1'b1;
      end
   endtask

   task automatic m_complete(input logic [7:0] w, input logic rdy);
      if (!m_rx_valid || rdy) begin
         m_rx_valid = 1'b1;
         m_rx_data  = w;
      end else begin
         m_ov = 1'b1;
      end
   endtask

   task automatic check_state(input string name);
      check({name, ".rx_valid"}, bus.RX_VALID, m_rx_valid);
      check({name, ".rx_data"}, bus.RX_DATA, m_rx_data);
      check({name, ".overrun"}, bus.OVERRUN, m_ov);
      check({name, ".underrun"}, bus.UNDERRUN, m_un);
      check({name, ".tx_ready"}, bus.TX_READY, !m_hold_full);
   endtask

   task automatic check_reset(input string name);
      check({name, ".miso"}, bus.SPI_MISO, 0);
      check({name, ".miso_oe"}, bus.SPI_MISO_OE, 0);
      check({name, ".tx_ready"}, bus.TX_READY, 1);
      check({name, ".rx_valid"}, bus.RX_VALID, 0);
      check({name, ".rx_data"}, bus.RX_DATA, 0);
      check({name, ".busy"}, bus.BUSY, 0);
      check({name, ".overrun"}, bus.OVERRUN, 0);
      check({name, ".underrun"}, bus.UNDERRUN, 0);
   endtask

   task automatic tx_write(input logic [7:0] d);
      int t = 0;
      while (bus.TX_READY !== 1'b1 && t < 50) begin
         cyc(1);
         t++;
      end
      check("tx_ready_wait", bus.TX_READY, 1);
      bus.TX_DATA  = d;
      bus.TX_VALID = 1'b1;
      cyc(1);
      bus.TX_VALID = 1'b0;
      check("tx_ready_after_write", bus.TX_READY, 0);
      m_hold_full = 1'b1;
      m_hold      = d;
   endtask

   task automatic rx_accept();
      bus.RX_READY = 1'b1;
      cyc(1);
      bus.RX_READY = 1'b0;
      m_rx_valid = 1'b0;
   endtask

   task automatic err_clr();
      bus.ERR_CLR = 1'b1;
      cyc(1);
      bus.ERR_CLR = 1'b0;
      m_ov = 1'b0;
      m_un = 1'b0;
   endtask

   // side: 0 plain, 1 ERR_CLR in the load cycle, 2 TX write in the load cycle.
   task automatic csn_low(input int side, input logic [7:0] d);
      bus.SPI_CSN = 1'b0;
      cyc(SYNC_STAGES);
      check("csn_fall_pre_ready", bus.TX_READY, !m_hold_full);
      check("csn_fall_pre_busy", bus.BUSY, 0);
      if (side == 1) bus.ERR_CLR = 1'b1;
      if (side == 2) begin
         bus.TX_DATA  = d;
         bus.TX_VALID = 1'b1;
      end
      cyc(1);
      bus.ERR_CLR  = 1'b0;
      bus.TX_VALID = 1'b0;
      if (side == 1) begin
         m_ov = 1'b0;
         m_un = 1'b0;
      end
      m_load(m_cur);
      if (side == 2) begin
         m_hold_full = 1'b1;
         m_hold      = d;
      end
      check("csn_fall_ready", bus.TX_READY, !m_hold_full);
      check("csn_fall_busy", bus.BUSY, 1);
      check("csn_fall_miso", bus.SPI_MISO, m_cur[7]);
      cyc(PH - SYNC_STAGES - 1);
   endtask

   task automatic csn_high();
      cyc(PH);
      bus.SPI_CSN = 1'b1;
      cyc(SYNC_STAGES);
      check("csn_rise_pre_busy", bus.BUSY, 1);
      cyc(1);
      check("csn_rise_busy", bus.BUSY, 0);
      check("csn_rise_oe", bus.SPI_MISO_OE, 0);
      check("csn_rise_miso", bus.SPI_MISO, 0);
      cyc(PH);
   endtask

   task automatic frame(input logic [7:0] mosi, input int nbits, input logic rdy_end,
                        input logic wr_mid, input logic [7:0] wr_data,
                        output logic [7:0] got);
      got = '0;
      for (int i = 0; i < nbits; i++) begin
         bus.SPI_MOSI = mosi[7-i];
         cyc(PH);
         got[7-i]    = bus.SPI_MISO;
         bus.SPI_SCK = 1'b1;
         if (i == WIDTH - 1 && rdy_end) begin
            // RX_READY lands exactly in the cycle the completed word is registered.
            cyc(SYNC_STAGES);
            bus.RX_READY = 1'b1;
            cyc(1);
            bus.RX_READY = 1'b0;
            cyc(PH - SYNC_STAGES - 1);
         end else begin
            cyc(PH);
         end
         bus.SPI_SCK = 1'b0;
         if (i == 3 && wr_mid) tx_write(wr_data);
      end
      cyc(PH);
      if (nbits == WIDTH) begin
         check("miso_word", got, m_cur);
         m_complete(mosi, rdy_end);
         m_load(m_cur);
      end
   endtask

   // Cycle monitor: select latency, OE/MISO idle, RX hold and sticky flags.
   logic [SYNC_STAGES:0] csn_hist;
   logic                 p_valid, p_ready, p_ov, p_un, p_clr;
   logic [7:0]           p_data;

   always @(posedge clk) begin
      if (!res_n) begin
         csn_hist <= '1;
         p_valid  <= 1'b0;
         p_ready  <= 1'b0;
         p_ov     <= 1'b0;
         p_un     <= 1'b0;
         p_clr    <= 1'b0;
         p_data   <= '0;
      end else begin
         csn_hist <= {csn_hist[SYNC_STAGES-1:0], bus.SPI_CSN};
         p_valid  <= bus.RX_VALID;
         p_ready  <= bus.RX_READY;
         p_ov     <= bus.OVERRUN;
         p_un     <= bus.UNDERRUN;
         p_clr    <= bus.ERR_CLR;
         p_data   <= bus.RX_DATA;
      end
   end

   always @(negedge clk) begin
      if (res_n) begin
         check("mon_busy", bus.BUSY, !csn_hist[SYNC_STAGES]);
         check("mon_oe", bus.SPI_MISO_OE, !csn_hist[SYNC_STAGES]);
         if (!bus.SPI_MISO_OE) check("mon_miso_idle", bus.SPI_MISO, 0);
         if (p_valid && !p_ready) begin
            check("mon_rx_hold_valid", bus.RX_VALID, 1);
            check("mon_rx_hold_data", bus.RX_DATA, p_data);
         end
         if (p_ov && !p_clr) check("mon_ov_sticky", bus.OVERRUN, 1);
         if (p_un && !p_clr) check("mon_un_sticky", bus.UNDERRUN, 1);
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] got;
      int         side, nf, nb;
      logic       wr;

      bus.SPI_SCK  = 1'b0;
      bus.SPI_MOSI = 1'b0;
      bus.SPI_CSN  = 1'b1;
      bus.TX_DATA  = '0;
      bus.TX_VALID = 1'b0;
      bus.RX_READY = 1'b0;
      bus.ERR_CLR  = 1'b0;
      cyc(3);
      check_reset("reset");
      res_n = 1'b1;
      cyc(2);

      // Basic exchange.
      tx_write(8'hA5);
      csn_low(0, 8'h00);
      frame(8'h3C, 8, 1'b0, 1'b0, 8'h00, got);
      check("basic_miso", got, 8'hA5);
      csn_high();
      check("basic_rx_data", bus.RX_DATA, 8'h3C);
      check("basic_rx_valid", bus.RX_VALID, 1);
      check_state("basic");
      rx_accept();
      err_clr();
      check_state("basic_clr");

      // Three words back to back; third holding slot left empty.
      tx_write(8'h01);
      csn_low(0, 8'h00);
      frame(8'h81, 8, 1'b1, 1'b1, 8'h02, got);
      check("b2b_miso0", got, 8'h01);
      check("b2b_un0", bus.UNDERRUN, 0);
      frame(8'h42, 8, 1'b1, 1'b0, 8'h00, got);
      check("b2b_miso1", got, 8'h02);
      check("b2b_un1", bus.UNDERRUN, 1);
      frame(8'h24, 8, 1'b1, 1'b0, 8'h00, got);
      check("b2b_miso2", got, 8'hFF);
      csn_high();
      check_state("b2b");
      rx_accept();
      err_clr();

      // Overrun.
      csn_low(0, 8'h00);
      frame(8'h11, 8, 1'b0, 1'b0, 8'h00, got);
      frame(8'h22, 8, 1'b0, 1'b0, 8'h00, got);
      csn_high();
      check("ovr_rx_data", bus.RX_DATA, 8'h11);
      check("ovr_flag", bus.OVERRUN, 1);
      check_state("ovr");
      err_clr();
      check("ovr_cleared", bus.OVERRUN, 0);
      rx_accept();
      check("ovr_rx_valid_drop", bus.RX_VALID, 0);
      check_state("ovr_after");

      // Abort after five bits.
      csn_low(0, 8'h00);
      frame(8'hF0, 5, 1'b0, 1'b0, 8'h00, got);
      csn_high();
      check("abort_rx_valid", bus.RX_VALID, 0);
      check("abort_ovr", bus.OVERRUN, 0);
      check_state("abort");

      // RX_READY in the completion cycle.
      csn_low(0, 8'h00);
      frame(8'h5A, 8, 1'b0, 1'b0, 8'h00, got);
      frame(8'hC3, 8, 1'b1, 1'b0, 8'h00, got);
      check("sim_rx_valid", bus.RX_VALID, 1);
      check("sim_rx_data", bus.RX_DATA, 8'hC3);
      check("sim_ovr", bus.OVERRUN, 0);
      csn_high();
      check_state("sim_rx");
      rx_accept();

      // ERR_CLR in the same cycle as an underrun load.
      check("pre_clr_un", bus.UNDERRUN, 1);
      csn_low(1, 8'h00);
      check("clr_vs_un", bus.UNDERRUN, 1);
      frame(8'h99, 8, 1'b1, 1'b0, 8'h00, got);
      csn_high();
      check_state("clr_un");
      rx_accept();

      // TX write in the same cycle as a load: no bypass.
      err_clr();
      csn_low(2, 8'h77);
      check("nobypass_un", bus.UNDERRUN, 1);
      check("nobypass_ready", bus.TX_READY, 0);
      frame(8'h12, 8, 1'b1, 1'b0, 8'h00, got);
      check("nobypass_miso0", got, 8'hFF);
      frame(8'h34, 8, 1'b1, 1'b0, 8'h00, got);
      check("nobypass_miso1", got, 8'h77);
      csn_high();
      check_state("nobypass");

      // Random sessions.
      for (int s = 0; s < 30; s++) begin
         if ($urandom_range(0, 1) == 1 && !m_hold_full) tx_write(8'($urandom));
         if ($urandom_range(0, 2) == 0) rx_accept();
         if ($urandom_range(0, 3) == 0) err_clr();
         side = m_hold_full ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 2));
         csn_low(side, 8'($urandom));
         nf = int'($urandom_range(1, 3));
         for (int f = 0; f < nf; f++) begin
            nb = (f == nf - 1 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 8;
            wr = !m_hold_full && ($urandom_range(0, 1) == 1);
            frame(8'($urandom), nb, 1'($urandom_range(0, 1)), wr, 8'($urandom), got);
            check_state("rand_frame");
         end
         csn_high();
         check_state("rand_end");
      end

      // Reset in the middle of a transfer.
      tx_write(8'h5E);
      csn_low(0, 8'h00);
      frame(8'hAB, 3, 1'b0, 1'b0, 8'h00, got);
      res_n = 1'b0;
      #1;
      check_reset("reset_mid");
      bus.SPI_CSN  = 1'b1;
      bus.SPI_SCK  = 1'b0;
      bus.SPI_MOSI = 1'b0;
      m_hold_full  = 1'b0;
      m_hold       = '0;
      m_rx_valid   = 1'b0;
      m_rx_data    = '0;
      m_ov         = 1'b0;
      m_un         = 1'b0;
      cyc(2);
      res_n = 1'b1;
      cyc(2);
      tx_write(8'h96);
      csn_low(0, 8'h00);
      frame(8'h69, 8, 1'b0, 1'b0, 8'h00, got);
      check("post_reset_miso", got, 8'h96);
      csn_high();
      check("post_reset_rx_data", bus.RX_DATA, 8'h69);
      check("post_reset_rx_valid", bus.RX_VALID, 1);
      check_state("post_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/darkspi_slave.md
Name: darkspi_slave

Overview:
- SPI responder (mode 0, MSB-first) that sits as the far end of the SoC's SPI master link.
- Used on companion boards, and as an in-bench target for the master's SCK/MOSI/MISO/CSN pins.
- Oversamples SPI pins in the CLK domain and exposes byte-wide RX/TX valid/ready handshakes to local logic, with sticky overrun/underrun error flags.

Parameters:
- WIDTH, 8, frame length in bits.
- SYNC_STAGES, 2, synchroniser flops on SCK/MOSI/CSN, minimum 2.
- IDLE_WORD, 8'hFF, word shifted out when the TX holding register is empty.

Ports:
- CLK  in  1  system clock.
- RES  in  1  reset, asynchronous, active-low.
- SPI_SCK  in  1  SPI clock from master.
- SPI_MOSI  in  1  master-out data.
- SPI_CSN  in  1  chip select, active-low.
- SPI_MISO  out  1  slave-out data.
- SPI_MISO_OE  out  1  MISO output enable; high only while selected.
- TX_DATA  in  WIDTH  word to transmit.
- TX_VALID  in  1  TX_DATA valid.
- TX_READY  out  1  holding register empty.
- RX_DATA  out  WIDTH  received word.
- RX_VALID  out  1  RX_DATA valid; held until accepted.
- RX_READY  in  1  consumer accepts RX_DATA.
- BUSY  out  1  synchronised CSN low.
- OVERRUN  out  1  sticky: a received word was dropped.
- UNDERRUN  out  1  sticky: IDLE_WORD was sent.
- ERR_CLR  in  1  clears OVERRUN/UNDERRUN.

Behaviour:
- Reset (RES low, async): MISO=0, MISO_OE=0, TX_READY=1, RX_VALID=0, RX_DATA=0, BUSY=0, OVERRUN=0, UNDERRUN=0. Synchronisers reset to CSN=1, SCK=0, MOSI=0. Bit counter 0, both shift registers 0.
- Constraints: SCK high and low phases must each be ≥ SYNC_STAGES+2 CLK cycles. CSN setup/hold to SCK edges is ≥ 1 SCK phase.
- Edge detect: an edge is registered when the last sync stage differs from its delayed copy. It acts SYNC_STAGES+1 CLK cycles after the pin edge.
- CSN falling: BUSY=1, MISO_OE=1, bit counter cleared.
  - TX shifter loads the holding register if full; TX_READY rises the next cycle.
  - If the holding register is empty, loads IDLE_WORD and sets UNDERRUN.
  - MISO drives shifter MSB in the same cycle.
- SCK rising, selected: MOSI shifts into the RX shifter LSB and the bit counter increments.
  - On count reaching WIDTH: counter goes to 0 and the word completes in that same CLK cycle.
  - If RX_VALID=0, or RX_READY=1 that cycle: RX_DATA is updated and RX_VALID=1 on that edge.
  - Otherwise the word is dropped, RX_DATA is unchanged, and OVERRUN is set.
- SCK falling, selected:
  - If counter ≠ 0: TX shifter shifts left and MISO is the new MSB.
  - If counter = 0 and at least one word has completed this selection: load the next word (holding register or IDLE_WORD + UNDERRUN), as on CSN fall.
  - First falling edge after CSN fall with counter = 0 and no bit sampled: no action.
- CSN rising: BUSY=0, MISO_OE=0, MISO=0.
  - Partial RX word is discarded with no RX_VALID and no error.
  - A loaded TX word counts as consumed.
  - Counter is cleared.
- RX handshake: RX_VALID clears on RX_VALID & RX_READY unless a new word completes the same cycle, in which case it stays 1 with new data.
- TX handshake: TX_VALID & TX_READY writes the holding register; TX_READY=0 from the next cycle.
  - A write in the same cycle as a shifter load does not bypass: the load uses the old (empty) state and sends IDLE_WORD with UNDERRUN set; the written word stays in the holding register.
- ERR_CLR: clears both flags. If an error event occurs the same cycle, the event wins and the flag stays 1.
- SCK edges while CSN high are ignored entirely.

Test Plan:
- Reset mid-transfer: assert RES after 3 bits -> all outputs at reset values immediately; next full frame works normally.
- Basic exchange: preload TX 8'hA5, master sends 8'h3C -> master reads 8'hA5; RX_DATA=8'h3C with RX_VALID=1; TX_READY returns 1 one cycle after CSN fall.
- Back-to-back 3 words with CSN held low: TX 8'h01/8'h02 written in time, third not written -> master reads 01, 02, FF; UNDERRUN=1 only after the third load.
- Overrun: RX_READY held 0 across two frames 8'h11, 8'h22 -> RX_DATA=8'h11, OVERRUN=1. ERR_CLR then clears it, and RX_READY pulse drops RX_VALID.
- CSN abort after 5 bits of 8'hF0 -> no RX_VALID, no OVERRUN; MISO_OE=0 and BUSY=0 within SYNC_STAGES+1 cycles.
- Simultaneous events: RX_READY=1 the cycle a new word completes -> RX_VALID stays 1 with new data, OVERRUN=0. ERR_CLR concurrent with underrun -> UNDERRUN=1.
